// File: rtl/useq_ctrl.sv
// useq_ctrl -- writable microprogram sequencer for the multicycle CPU datapath.
//
// A loadable micro-ROM supplies one microword per cycle. Each microword holds a
// sequencing field, a memory-wait flag, an interrupt-check flag and the raw
// control vector for the datapath. Two opcode-indexed dispatch tables give the
// targets for decode-style branches.
//
// Microword layout (UWORD_W = CTRL_W+4):
//   [UWORD_W-1:UWORD_W-2] SEQ    0 = upc+1, 1 = DISP1[opcode], 2 = DISP2[opcode], 3 = fetch (0)
//   [CTRL_W+1]            WAIT   stall while MIO_ready is low
//   [CTRL_W]              INTCHK a fetch from this word may enter the interrupt vector
//   [CTRL_W-1:0]          CTRL   control vector driven to the datapath
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   MIO_ready             memory/IO ready; low stalls WAIT-marked microwords
//   INT                   interrupt request, rising edge latched
//   opcode                dispatch index (IR[31:26])
//   ucode_we/addr/wdata   micro-ROM write port
//   disp_we/sel/idx/wdata dispatch table write port (sel 0 = table 1, 1 = table 2)
//   ctrl                  CTRL field of urom[upc]
//   upc                   current micro-PC
//   stall                 WAIT & ~MIO_ready
//   int_ack               one-cycle pulse in the cycle after interrupt entry
module useq_ctrl #(
   parameter int                 UADDR_W = 5,
   parameter int                 CTRL_W  = 16,
   parameter logic [UADDR_W-1:0] INT_VEC = 5'd30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 MIO_ready,
   input  logic                 INT,
   input  logic [5:0]           opcode,
   input  logic                 ucode_we,
   input  logic [UADDR_W-1:0]   ucode_addr,
   input  logic [CTRL_W+3:0]    ucode_wdata,
   input  logic                 disp_we,
   input  logic                 disp_sel,
   input  logic [5:0]           disp_idx,
   input  logic [UADDR_W-1:0]   disp_wdata,
   output logic [CTRL_W-1:0]    ctrl,
   output logic [UADDR_W-1:0]   upc,
   output logic                 stall,
   output logic                 int_ack
);

   localparam int UWORD_W = CTRL_W + 4;
   localparam int DEPTH   = 2**UADDR_W;

   typedef enum logic [1:0] {
      SEQ_NEXT  = 2'd0,
      SEQ_DISP1 = 2'd1,
      SEQ_DISP2 = 2'd2,
      SEQ_FETCH = 2'd3
   } seq_e;

   // Storage: combinational read, registered write, untouched by reset.
   logic [UWORD_W-1:0] urom  [DEPTH];
   logic [UADDR_W-1:0] disp1 [64];
   logic [UADDR_W-1:0] disp2 [64];

   logic [UWORD_W-1:0] uword;
   seq_e               seq;
   logic               wait_f;
   logic               intchk;

   logic               int_pending;
   logic               int_d;
   logic               int_rise;
   logic               take_int;
   logic               pend_nxt;
   logic [UADDR_W-1:0] upc_nxt;

   always_ff @(posedge clk) begin
      if (ucode_we)
         urom[ucode_addr] <= ucode_wdata;
      if (disp_we) begin
         if (disp_sel)
            disp2[disp_idx] <= disp_wdata;
         else
            disp1[disp_idx] <= disp_wdata;
      end
   end

   // Field decode of the current microword
   assign uword  = urom[upc];
   assign seq    = seq_e'(uword[UWORD_W-1 -: 2]);
   assign wait_f = uword[CTRL_W+1];
   assign intchk = uword[CTRL_W];
   assign ctrl   = uword[CTRL_W-1:0];
   assign stall  = wait_f & ~MIO_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         upc         <= '0;
         int_pending <= 1'b0;
         int_d       <= 1'b0;
         int_ack     <= 1'b0;
      end else begin
         upc         <= upc_nxt;
         int_pending <= pend_nxt;
         int_d       <= INT;
         int_ack     <= take_int;
      end
   end

   always_comb begin
      int_rise = INT & ~int_d;
      // Interrupts are only entered at an unstalled fetch that allows them.
      take_int = ~stall & (seq == SEQ_FETCH) & intchk & int_pending;
      // A new edge arriving in the same cycle as a take keeps the request alive.
      pend_nxt = int_rise | (int_pending & ~take_int);

      upc_nxt = upc;
      if (stall) begin
         upc_nxt = upc;
      end else if (take_int) begin
         upc_nxt = INT_VEC;
      end else begin
         case (seq)
            SEQ_NEXT:  upc_nxt = upc + UADDR_W'(1);
            SEQ_DISP1: upc_nxt = disp1[opcode];
            SEQ_DISP2: upc_nxt = disp2[opcode];
            SEQ_FETCH: upc_nxt = '0;
            default:   upc_nxt = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl -- directed test of useq_ctrl against a behavioural model.
// The model keeps its own copy of the micro-ROM and dispatch tables and steps
// the micro-PC from the microword rules; a negedge process compares every
// output each cycle. Directed literal checks pin the model at key points.
module tb_useq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MIO_ready = 1'b1;
   logic        INT = 1'b0;
   logic [5:0]  opcode = 6'h00;
   logic        ucode_we = 1'b0;
   logic [4:0]  ucode_addr = '0;
   logic [19:0] ucode_wdata = '0;
   logic        disp_we = 1'b0;
   logic        disp_sel = 1'b0;
   logic [5:0]  disp_idx = '0;
   logic [4:0]  disp_wdata = '0;
   logic [15:0] ctrl;
   logic [4:0]  upc;
   logic        stall;
   logic        int_ack;

   useq_ctrl #(.UADDR_W(5), .CTRL_W(16), .INT_VEC(5'd30)) dut (
      .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .INT(INT), .opcode(opcode),
      .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_wdata(ucode_wdata),
      .disp_we(disp_we), .disp_sel(disp_sel), .disp_idx(disp_idx), .disp_wdata(disp_wdata),
      .ctrl(ctrl), .upc(upc), .stall(stall), .int_ack(int_ack)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit loaded = 1'b0;

   // ---------------- behavioural model ----------------
   logic [19:0] m_rom [32];
   logic [4:0]  m_d1 [64];
   logic [4:0]  m_d2 [64];
   int          m_upc = 0;
   bit          m_pend = 0, m_intd = 0, m_ack = 0, m_valid = 0;

   initial begin
      for (int i = 0; i < 32; i++) m_rom[i] = '0;
      for (int i = 0; i < 64; i++) begin m_d1[i] = '0; m_d2[i] = '0; end
   end

   always @(posedge clk) begin
      logic [19:0] w;
      int  seqv, nu;
      bit  st, take, rise;
      w    = m_rom[m_upc];
      seqv = int'(w[19:18]);
      st   = w[17] && !MIO_ready;
      take = !st && seqv == 3 && w[16] && m_pend;
      rise = INT && !m_intd;
      if (st)        nu = m_upc;
      else if (take) nu = 30;
      else if (seqv == 0) nu = (m_upc + 1) % 32;
      else if (seqv == 1) nu = int'(m_d1[opcode]);
      else if (seqv == 2) nu = int'(m_d2[opcode]);
      else           nu = 0;
      if (reset) begin
         m_upc <= 0; m_pend <= 0; m_intd <= 0; m_ack <= 0; m_valid <= 1;
      end else begin
         m_upc <= nu; m_pend <= rise || (m_pend && !take); m_intd <= INT; m_ack <= take;
      end
      if (ucode_we) m_rom[ucode_addr] <= ucode_wdata;
      if (disp_we) begin
         if (disp_sel) m_d2[disp_idx] <= disp_wdata;
         else          m_d1[disp_idx] <= disp_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (loaded && m_valid) begin
         chk("model_upc", 32'(upc), 32'(m_upc));
         chk("model_ctrl", 32'(ctrl), 32'(m_rom[m_upc][15:0]));
         chk("model_stall", 32'(stall), 32'(m_rom[m_upc][17] && !MIO_ready));
         chk("model_int_ack", 32'(int_ack), 32'(m_ack));
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [19:0] mw(input logic [1:0] s, input logic wt,
                                      input logic ic, input logic [15:0] c);
      return {s, wt, ic, c};
   endfunction

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic wr_u(input logic [4:0] a, input logic [19:0] d);
      ucode_we = 1'b1; ucode_addr = a; ucode_wdata = d;
      cyc();
      ucode_we = 1'b0;
   endtask

   task automatic wr_d(input logic sel, input logic [5:0] idx, input logic [4:0] d);
      disp_we = 1'b1; disp_sel = sel; disp_idx = idx; disp_wdata = d;
      cyc();
      disp_we = 1'b0;
   endtask

   task automatic wait_upc(input logic [4:0] t);
      for (int k = 0; k < 20 && upc !== t; k++) cyc();
      chk("sync_upc", 32'(upc), 32'(t));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      cyc();
      // Bulk load while in reset: every microword fetches, tables zero.
      for (int i = 0; i < 32; i++) wr_u(5'(i), mw(2'd3, 1'b0, 1'b0, 16'hF000 + 16'(i)));
      for (int i = 0; i < 64; i++) begin wr_d(1'b0, 6'(i), 5'd0); wr_d(1'b1, 6'(i), 5'd0); end
      wr_u(5'd0, mw(2'd0, 1'b0, 1'b0, 16'h0001));
      wr_u(5'd1, mw(2'd1, 1'b0, 1'b0, 16'h0002));
      wr_d(1'b0, 6'h23, 5'd6);
      wr_u(5'd6, mw(2'd3, 1'b0, 1'b0, 16'h0040));
      opcode = 6'h23;
      loaded = 1'b1;
      cyc();

      // 1. defaults: 0,1,6,0
      reset = 1'b0;
      chk("t1_upc0", 32'(upc), 32'd0);   chk("t1_ctrl0", 32'(ctrl), 32'h0001);
      chk("t1_model_upc0", 32'(m_upc), 32'd0);
      cyc(); chk("t1_upc1", 32'(upc), 32'd1); chk("t1_ctrl1", 32'(ctrl), 32'h0002);
      cyc(); chk("t1_upc6", 32'(upc), 32'd6); chk("t1_ctrl6", 32'(ctrl), 32'h0040);
      cyc(); chk("t1_upc0b", 32'(upc), 32'd0); chk("t1_ctrl0b", 32'(ctrl), 32'h0001);

      // 2. stall on urom[0] WAIT for 3 cycles
      wr_u(5'd0, mw(2'd0, 1'b1, 1'b0, 16'h0001));     // now at 1
      cyc();                                          // at 6
      MIO_ready = 1'b0;
      cyc(); chk("t2_upc_s1", 32'(upc), 32'd0); chk("t2_stall1", 32'(stall), 32'd1);
      chk("t2_model_stall", 32'(m_rom[m_upc][17]), 32'd1);
      cyc(); chk("t2_upc_s2", 32'(upc), 32'd0); chk("t2_ctrl_s2", 32'(ctrl), 32'h0001);
      cyc(); chk("t2_upc_s3", 32'(upc), 32'd0); chk("t2_stall3", 32'(stall), 32'd1);
      MIO_ready = 1'b1;
      #1 chk("t2_stall4", 32'(stall), 32'd0); chk("t2_upc_s4", 32'(upc), 32'd0);
      cyc(); chk("t2_upc_go", 32'(upc), 32'd1);

      // 3. interrupt via urom[6] INTCHK; level-held INT does not retrigger
      ucode_we = 1'b1; ucode_addr = 5'd6; ucode_wdata = mw(2'd3, 1'b0, 1'b1, 16'h0040);
      INT = 1'b1;
      cyc(); ucode_we = 1'b0;
      chk("t3_upc6", 32'(upc), 32'd6); chk("t3_ack0", 32'(int_ack), 32'd0);
      cyc(); chk("t3_upc30", 32'(upc), 32'd30); chk("t3_ack1", 32'(int_ack), 32'd1);
      chk("t3_model_ack", 32'(m_ack), 32'd1);
      cyc(); chk("t3_upc0", 32'(upc), 32'd0); chk("t3_ack_clr", 32'(int_ack), 32'd0);
      cyc(); cyc(); chk("t3_upc6b", 32'(upc), 32'd6);
      cyc(); chk("t3_no_reentry", 32'(upc), 32'd0); chk("t3_ack_none", 32'(int_ack), 32'd0);
      INT = 1'b0;

      // 4. wrap at 31, dispatch table 2, same-entry dispatch write/read
      wr_u(5'd31, mw(2'd0, 1'b0, 1'b0, 16'h131F));
      wr_d(1'b0, 6'h10, 5'd31);
      wr_u(5'd2, mw(2'd2, 1'b0, 1'b0, 16'h2222));
      wr_d(1'b1, 6'h2b, 5'd9);
      wr_u(5'd9, mw(2'd3, 1'b0, 1'b0, 16'h0099));
      wr_d(1'b0, 6'h11, 5'd2);
      wait_upc(5'd0);
      opcode = 6'h10;
      cyc(); chk("t4_upc1", 32'(upc), 32'd1);
      cyc(); chk("t4_upc31", 32'(upc), 32'd31); chk("t4_ctrl31", 32'(ctrl), 32'h131F);
      cyc(); chk("t4_wrap", 32'(upc), 32'd0);
      opcode = 6'h11;
      cyc(); chk("t4_upc1b", 32'(upc), 32'd1);
      wr_d(1'b0, 6'h11, 5'd5);                         // same-cycle read sees old 2
      chk("t4_disp_old", 32'(upc), 32'd2);
      opcode = 6'h2b;
      cyc(); chk("t4_disp2", 32'(upc), 32'd9); chk("t4_ctrl9", 32'(ctrl), 32'h0099);
      cyc(); chk("t4_back0", 32'(upc), 32'd0);

      // 5. reset during a stall with an interrupt pending
      INT = 1'b1; MIO_ready = 1'b0;
      cyc(); chk("t5_stall", 32'(stall), 32'd1);
      cyc(); chk("t5_pend", 32'(m_pend), 32'd1);
      reset = 1'b1; INT = 1'b0;
      cyc(); chk("t5_rst_upc", 32'(upc), 32'd0); chk("t5_rst_ack", 32'(int_ack), 32'd0);
      chk("t5_rst_stall", 32'(stall), 32'd1);
      reset = 1'b0; MIO_ready = 1'b1; opcode = 6'h23;
      cyc(); chk("t5_upc1", 32'(upc), 32'd1);
      cyc(); chk("t5_upc6", 32'(upc), 32'd6);
      cyc(); chk("t5_pend_cleared", 32'(upc), 32'd0);

      // 6. live write of the current word; rise and take on the same edge
      wr_u(5'd1, mw(2'd1, 1'b1, 1'b0, 16'h0002));      // now at 1 with WAIT
      MIO_ready = 1'b0; INT = 1'b1;
      ucode_we = 1'b1; ucode_addr = 5'd1; ucode_wdata = mw(2'd1, 1'b1, 1'b0, 16'hBEEF);
      #1 chk("t6_ctrl_old", 32'(ctrl), 32'h0002); chk("t6_stall", 32'(stall), 32'd1);
      cyc(); ucode_we = 1'b0;
      chk("t6_ctrl_new", 32'(ctrl), 32'hBEEF); chk("t6_upc_hold", 32'(upc), 32'd1);
      INT = 1'b0; MIO_ready = 1'b1;
      cyc(); chk("t6_upc6", 32'(upc), 32'd6);
      INT = 1'b1;
      cyc(); chk("t6_take1", 32'(upc), 32'd30); chk("t6_ack1", 32'(int_ack), 32'd1);
      INT = 1'b0;
      cyc(); chk("t6_upc0", 32'(upc), 32'd0);
      cyc(); cyc(); chk("t6_upc6b", 32'(upc), 32'd6);
      cyc(); chk("t6_take2", 32'(upc), 32'd30); chk("t6_ack2", 32'(int_ack), 32'd1);
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
